// File: rtl/acc_window_seq.sv
// acc_window_seq
//   Upstream sequencer for the window accumulator. Splits a valid/ready sample
//   stream into windows of a programmable length. For each window it issues
//   one clear cycle, then one enable cycle per accepted sample, then pulses
//   win_done_o in the cycle the accumulator result holds the window sum.
//
// Ports
//   clk         clock, rising edge
//   rst_ni      asynchronous active-low reset
//   run_i       level; windows run back-to-back while high
//   cfg_len_i   samples per window (0 treated as 1), latched at window start
//   s_valid_i   upstream sample valid
//   s_ready_o   sequencer ready for a sample
//   s_data_i    signed upstream sample
//   en_o        accumulator enable
//   clear_o     accumulator clear
//   data_o      signed accumulator data, holds its last value between samples
//   win_done_o  one-cycle pulse: accumulator result is the completed window sum
//   busy_o      high whenever the sequencer is not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for run_i; window length latched on exit
// CLEAR | clear_o high for one cycle, sample counter zeroed
// ACCUM | ready for samples; each handshake gives en_o next cycle
// DRAIN | last en_o high, no longer ready
// DONE  | win_done_o high; restart with fresh CLEAR if run_i still high
module acc_window_seq #(
    parameter int DIN_WIDTH = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_ni,
    input  logic                        run_i,
    input  logic [LEN_WIDTH-1:0]        cfg_len_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic signed [DIN_WIDTH-1:0] s_data_i,
    output logic                        en_o,
    output logic                        clear_o,
    output logic signed [DIN_WIDTH-1:0] data_o,
    output logic                        win_done_o,
    output logic                        busy_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_eff;
    logic                 hs;

    // s_ready_o is a register that is high exactly while in ACCUM, so the
    // handshake never depends combinationally on an output.
    assign hs      = s_valid_i & s_ready_o;
    assign len_eff = (cfg_len_i == '0) ? LEN_WIDTH'(1) : cfg_len_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            s_ready_o  <= 1'b0;
            en_o       <= 1'b0;
            clear_o    <= 1'b0;
            data_o     <= '0;
            win_done_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            en_o       <= 1'b0;
            clear_o    <= 1'b0;
            win_done_o <= 1'b0;
            s_ready_o  <= 1'b0;
            busy_o     <= 1'b1;
            case (state)
                IDLE: begin
                    if (run_i) begin
                        len_q   <= len_eff;
                        clear_o <= 1'b1;
                        state   <= CLEAR;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                CLEAR: begin
                    cnt       <= '0;
                    s_ready_o <= 1'b1;
                    state     <= ACCUM;
                end
                ACCUM: begin
                    s_ready_o <= 1'b1;
                    if (hs) begin
                        en_o   <= 1'b1;
                        data_o <= s_data_i;
                        cnt    <= cnt + LEN_WIDTH'(1);
                        // terminal compare leaves ACCUM, so cnt never wraps
                        if (cnt == len_q - LEN_WIDTH'(1)) begin
                            s_ready_o <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    win_done_o <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (run_i) begin
                        len_q   <= len_eff;
                        clear_o <= 1'b1;
                        state   <= CLEAR;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_window_seq.sv
module tb_acc_window_seq;

    logic               clk;
    logic               rst_ni;
    logic               run_i;
    logic [15:0]        cfg_len_i;
    logic               s_valid_i;
    logic               s_ready_o;
    logic signed [31:0] s_data_i;
    logic               en_o;
    logic               clear_o;
    logic signed [31:0] data_o;
    logic               win_done_o;
    logic               busy_o;

    acc_window_seq #(.DIN_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .run_i      (run_i),
        .cfg_len_i  (cfg_len_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .en_o       (en_o),
        .clear_o    (clear_o),
        .data_o     (data_o),
        .win_done_o (win_done_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream accumulator fed by the sequencer outputs
    logic [31:0] acc;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)      acc <= '0;
        else if (clear_o) acc <= '0;
        else if (en_o)    acc <= acc + data_o;
    end

    int n_vec = 0;
    int n_err = 0;

    // reference model: window bookkeeping by cycle timestamps
    int          cyc      = 0;
    bit          m_busy   = 0;
    int          m_left   = 0;
    int          clear_at = -1;
    int          done_at  = -1;
    bit          m_en     = 0;
    logic [31:0] m_data   = '0;
    logic [31:0] m_sum    = '0;

    // observation helpers
    int          done_n = 0;
    logic [31:0] done_q[$];
    int          dut_hs = 0;
    int          gap    = 0;
    bit          chk_ce = 0;
    bit          saw_clr = 0;
    bit          ce_bad = 0;
    logic [31:0] feed_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_left = 0; clear_at = -1; done_at = -1;
        m_en = 0; m_data = '0; m_sum = '0;
    endtask

    task automatic model_start(input int len);
        m_busy   = 1;
        m_left   = (len == 0) ? 1 : len;
        clear_at = cyc + 1;
        m_sum    = '0;
    endtask

    task automatic step(input bit run, input int len, input bit valid, input logic [31:0] data);
        bit e_clr, e_done, e_rdy, hs;
        e_clr  = (cyc == clear_at);
        e_done = (cyc == done_at);
        e_rdy  = m_busy && (m_left > 0) && (cyc > clear_at);
        chk("clear_o", clear_o, e_clr);
        chk("s_ready_o", s_ready_o, e_rdy);
        chk("en_o", en_o, m_en);
        chk("data_o", data_o, m_data);
        chk("win_done_o", win_done_o, e_done);
        chk("busy_o", busy_o, m_busy);
        if (e_done) chk("result", acc, m_sum);
        if (win_done_o) begin done_n++; done_q.push_back(acc); end
        if (s_ready_o && valid) dut_hs++;
        else if (dut_hs == 2 && !s_ready_o) gap++;
        if (chk_ce) begin
            if (clear_o) saw_clr = 1;
            if (en_o && !saw_clr) ce_bad = 1;
        end
        run_i = run; cfg_len_i = 16'(len); s_valid_i = valid; s_data_i = data;
        hs   = e_rdy && valid;
        m_en = hs;
        if (hs) begin
            m_data = data;
            m_sum  = m_sum + data;
            m_left--;
            if (m_left == 0) done_at = cyc + 2;
        end
        if (cyc == done_at) begin
            if (run) model_start(len);
            else     m_busy = 0;
        end else if (!m_busy && run) begin
            model_start(len);
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        run_i = 0; s_valid_i = 0;
        rst_ni = 0;
        #1;
        chk("rst en_o", en_o, 0);
        chk("rst clear_o", clear_o, 0);
        chk("rst s_ready_o", s_ready_o, 0);
        chk("rst win_done_o", win_done_o, 0);
        chk("rst busy_o", busy_o, 0);
        chk("rst data_o", data_o, 0);
        model_reset();
        @(posedge clk); #1;
        rst_ni = 1;
        @(posedge clk); #1;
    endtask

    // feed_q samples with valid held high; run_i drops after drop_after accepted
    task automatic feed(input int len, input int drop_after);
        int  nacc, k;
        bit  rdy, v;
        nacc = 0; k = 0;
        while ((feed_q.size() > 0 || busy_o) && k < 200) begin
            rdy = s_ready_o;
            v   = feed_q.size() > 0;
            step(nacc < drop_after, len, v, v ? feed_q[0] : 32'd0);
            if (rdy && v) begin void'(feed_q.pop_front()); nacc++; end
            k++;
        end
        chk("feed timeout", (k >= 200) ? 32'd1 : 32'd0, 32'd0);
    endtask

    typedef struct {
        bit          run;
        int          len;
        bit          valid;
        logic [31:0] data;
        bit          e_clr, e_rdy, e_en;
        logic [31:0] e_data;
        bit          e_done, e_busy;
        logic [31:0] e_acc;
    } vec_t;

    function automatic vec_t mk(bit run, int len, bit valid, logic [31:0] data,
                                bit c, bit r, bit e, logic [31:0] d, bit dn, bit b,
                                logic [31:0] a);
        vec_t v;
        v.run = run; v.len = len; v.valid = valid; v.data = data;
        v.e_clr = c; v.e_rdy = r; v.e_en = e; v.e_data = d;
        v.e_done = dn; v.e_busy = b; v.e_acc = a;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        int saved;
        tbl[0]  = mk(1, 4, 0, 0,          0, 0, 0, 0,          0, 0, 0);
        tbl[1]  = mk(1, 4, 1, 1,          1, 0, 0, 0,          0, 1, 0);
        tbl[2]  = mk(1, 4, 1, 1,          0, 1, 0, 0,          0, 1, 0);
        tbl[3]  = mk(1, 4, 1, 2,          0, 1, 1, 1,          0, 1, 0);
        tbl[4]  = mk(1, 4, 1, 3,          0, 1, 1, 2,          0, 1, 0);
        tbl[5]  = mk(1, 4, 1, 4,          0, 1, 1, 3,          0, 1, 0);
        tbl[6]  = mk(0, 4, 0, 0,          0, 0, 1, 4,          0, 1, 0);
        tbl[7]  = mk(0, 4, 0, 0,          0, 0, 0, 4,          1, 1, 10);
        tbl[8]  = mk(1, 0, 0, 0,          0, 0, 0, 4,          0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 32'hFFFFFFF9, 1, 0, 0, 4,        0, 1, 0);
        tbl[10] = mk(0, 0, 1, 32'hFFFFFFF9, 0, 1, 0, 4,        0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0,          0, 0, 1, 32'hFFFFFFF9, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0,          0, 0, 0, 32'hFFFFFFF9, 1, 1, 32'hFFFFFFF9);
        tbl[13] = mk(0, 0, 0, 0,          0, 0, 0, 32'hFFFFFFF9, 0, 0, 0);

        rst_ni = 1; run_i = 0; cfg_len_i = '0; s_valid_i = 0; s_data_i = '0;
        #2;
        do_reset();

        // directed table: length 4 window, then length 0 treated as 1
        for (int i = 0; i < 14; i++) begin
            chk("tbl clear_o", clear_o, tbl[i].e_clr);
            chk("tbl s_ready_o", s_ready_o, tbl[i].e_rdy);
            chk("tbl en_o", en_o, tbl[i].e_en);
            chk("tbl data_o", data_o, tbl[i].e_data);
            chk("tbl win_done_o", win_done_o, tbl[i].e_done);
            chk("tbl busy_o", busy_o, tbl[i].e_busy);
            if (tbl[i].e_done) chk("tbl result", acc, tbl[i].e_acc);
            step(tbl[i].run, tbl[i].len, tbl[i].valid, tbl[i].data);
        end

        // gapped valid: 1,0,0,1,0,1 with samples 5,6,7
        done_q.delete();
        step(1, 3, 0, 0);
        step(1, 3, 0, 0);
        step(0, 3, 1, 5);
        step(0, 3, 0, 0);
        step(0, 3, 0, 0);
        step(0, 3, 1, 6);
        step(0, 3, 0, 0);
        step(0, 3, 1, 7);
        for (int i = 0; i < 4; i++) step(0, 3, 0, 0);
        chk("gap done count", done_q.size(), 1);
        if (done_q.size() > 0) chk("gap sum", done_q[0], 18);

        // back-to-back windows of 2
        done_q.delete(); dut_hs = 0; gap = 0;
        feed_q = '{32'd1, 32'd1, 32'd3, 32'd3};
        feed(2, 4);
        chk("b2b done count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b sum0", done_q[0], 2);
            chk("b2b sum1", done_q[1], 6);
        end
        chk("b2b gap", gap, 3);

        // run_i drops after the first sample; window still completes
        done_q.delete();
        feed_q = '{32'd10, 32'hFFFFFFFE, 32'd4};
        feed(3, 1);
        step(0, 3, 0, 0);
        chk("drop done count", done_q.size(), 1);
        if (done_q.size() > 0) chk("drop sum", done_q[0], 12);
        chk("drop busy", busy_o, 0);

        // reset after 2 of 4 samples
        for (int k = 0, n = 0; n < 2 && k < 20; k++) begin
            bit rdy;
            rdy = s_ready_o;
            step(1, 4, 1, 32'd8);
            if (rdy) n++;
        end
        saved = done_n;
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 4, 0, 0);
        chk("partial no done", done_n, saved);
        chk_ce = 1; saw_clr = 0; ce_bad = 0;
        feed_q = '{32'd9, 32'd9};
        feed(2, 2);
        chk_ce = 0;
        chk("clear before en", ce_bad, 0);
        chk("clear seen", saw_clr, 1);

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step($urandom_range(0, 7) != 0, $urandom_range(0, 4),
                 $urandom_range(0, 1) == 1, $urandom);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
